mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single cache request port (req_mode/req_addr/req_wdata/req_wstrb, one-cycle response_enable) between the
//  instruction-fetch and data-access units of the core. Latches pulsed requests, arbitrates, issues one cache request at
//  a time and routes the response pulse and data back to the owning requester. Sits between fetch/mem stages and cache.
// PARAMETERS
//  none (widths fixed: addr/data 32, wstrb 4)
// PORTS
//  clk            in   1   clock
//  rstn           in   1   reset, synchronous, active-low
//  i_req          in   1   fetch request pulse (always read)
//  i_addr         in   32  fetch address
//  i_resp_en      out  1   fetch response pulse
//  i_resp_data    out  32  fetch read data
//  d_req          in   1   data request pulse
//  d_mode         in   1   MEMREQ_READ / MEMREQ_WRITE
//  d_addr         in   32  data address
//  d_wdata        in   32  write data
//  d_wstrb        in   4   write byte strobe
//  d_resp_en      out  1   data response pulse
//  d_resp_data    out  32  data read data (0 for writes)
//  mem_req_en     out  1   cache request_enable, exactly one-cycle pulse
//  mem_req_mode   out  1   cache req_mode
//  mem_req_addr   out  32  cache req_addr
//  mem_req_wdata  out  32  cache req_wdata
//  mem_req_wstrb  out  4   cache req_wstrb
//  mem_resp_en    in   1   cache response_enable
//  mem_resp_data  in   32  cache resp_data
// BEHAVIOUR
//  - Reset (rstn=0 at posedge): state=IDLE, both pending flags 0, all outputs 0, last_grant=DATA. Mid-op reset discards
//    outstanding and pending requests; no response is delivered afterwards.
//  - Per-requester latch: *_req pulse stores fields + pending=1; cleared when granted. A *_req from a requester whose
//    request is pending or outstanding is ignored (protocol violation, no state change).
//  - States: IDLE, WAIT_I, WAIT_D.
//    IDLE: candidates = pending | live *_req. None -> stay. Else grant winner; next cycle mem_req_en=1 with winner's
//      fields (live inputs if not yet latched), state -> WAIT_I/WAIT_D; loser stays/becomes pending.
//    WAIT_x: mem_req_en forced 0 after its single cycle; wait for mem_resp_en. On it: next cycle x_resp_en=1,
//      x_resp_data=mem_resp_data, state -> IDLE. Responses with state==IDLE are dropped.
//  - Latency: live pulse at cycle 0 in IDLE -> mem_req_en at cycle 1. mem_resp_en at cycle t -> x_resp_en at t+1;
//    next mem_req_en no earlier than t+2 (cache idle again at t+1).
//  - Fetch issues mem_req_mode=MEMREQ_READ, wdata=0, wstrb=0. Never more than one outstanding cache request.
//  - Tie (both candidates in IDLE): see CONFIGURATION. last_grant updated on every grant.
//  - mem_req_* fields hold their last value when mem_req_en=0; x_resp_data holds until next response.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: tie -> grant requester not in last_grant (alternates).
//  undefined: fixed priority, data wins every tie (fetch waits until no data candidate in IDLE).
// STRUCTURE
//  Shared package def.sv: MEMREQ_READ/MEMREQ_WRITE, typedef arb_state_t {IDLE,WAIT_I,WAIT_D},
//  typedef struct memreq_t {mode, addr, wdata, wstrb}, typedef enum arb_owner_t {OWNER_I, OWNER_D}.
//  Sub-module memreq_latch (one instance per requester): captures memreq_t on pulse, pending flag, clear on grant.
// TESTING
//  1 d_req write addr=0x100 wdata=0xDEADBEEF wstrb=0xF -> mem_req_en 1 cycle later, mode=WRITE; mem_resp_en -> d_resp_en
//    next cycle, i_resp_en stays 0.
//  2 i_req addr=0x40 alone, mem_resp_data=0x00000013 -> i_resp_en pulse with i_resp_data=0x13, one mem_req_en pulse.
//  3 i_req and d_req same cycle (addr 0x40/0x200) -> D issued first, I issued exactly 2 cycles after D response;
//    with ARB_ROUND_ROBIN_EN repeat tie -> second tie grants I first.
//  4 d_req held continuously, i_req pending, macro undefined -> I starved while D re-requests each IDLE; macro defined -> alternates.
//  5 rstn=0 during WAIT_D with I pending -> all outputs 0, later mem_resp_en produces no *_resp_en; new i_req served.
//  6 second i_req while I outstanding -> ignored, exactly one mem_req_en and one i_resp_en.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the fetch/data cache-port arbiter: request mode
// encodings, arbiter state and owner enums, the request record carried from
// each requester to the cache port, and a helper that builds a fetch request.
// Optional feature macro used by mem_arbiter: ARB_ROUND_ROBIN_EN.
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

   localparam logic MEMREQ_READ  = 1'b0;
   localparam logic MEMREQ_WRITE = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_I = 2'd1,
      WAIT_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } arb_owner_t;

   typedef struct packed {
      logic        mode;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } memreq_t;

   // Fetch requests are always reads with no write payload.
   function automatic memreq_t fetch_req(input logic [31:0] addr);
      memreq_t r;
      r.mode  = MEMREQ_READ;
      r.addr  = addr;
      r.wdata = 32'h0;
      r.wstrb = 4'h0;
      return r;
   endfunction

endpackage

// File: rtl/mem_arbiter_memreq_latch.sv
// ---------------------------------------------------------------------------
// memreq_latch
// Holds one requester's pulsed request until the arbiter grants it.
// Ports:
//   clk, rstn     clock, synchronous active-low reset
//   i_pulse       request pulse from the requester
//   i_fields      request fields presented with the pulse
//   i_block       requester already has a request outstanding at the cache
//   i_clear       arbiter grants this requester this cycle
//   o_pending     a latched request is waiting for a grant
//   o_fields      effective request: latched fields when pending, otherwise
//                 the live inputs (so a same-cycle grant can use them)
// ---------------------------------------------------------------------------
module memreq_latch
   import mem_arbiter_pkg::*;
(
   input  logic    clk,
   input  logic    rstn,
   input  logic    i_pulse,
   input  memreq_t i_fields,
   input  logic    i_block,
   input  logic    i_clear,
   output logic    o_pending,
   output memreq_t o_fields
);

   logic    r_pending;
   memreq_t r_fields;

   // A grant takes priority over capture: a live pulse that wins in the same
   // cycle goes straight to the cache and must not also be left pending.
   // Pulses while pending or outstanding are protocol violations and dropped.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_pending <= 1'b0;
         r_fields  <= '0;
      end else if (i_clear) begin
         r_pending <= 1'b0;
      end else if (i_pulse && !r_pending && !i_block) begin
         r_pending <= 1'b1;
         r_fields  <= i_fields;
      end
   end

   assign o_pending = r_pending;
   assign o_fields  = r_pending ? r_fields : i_fields;

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares the single cache request port between instruction fetch (I) and
// data access (D). Pulsed requests are latched per requester, one winner is
// issued to the cache at a time, and the cache response pulse/data is routed
// back to the owner one cycle later.
// Ports:
//   clk, rstn                    clock, synchronous active-low reset
//   i_req, i_addr                fetch request pulse and address (read only)
//   i_resp_en, i_resp_data       fetch response pulse and data
//   d_req, d_mode, d_addr,
//   d_wdata, d_wstrb             data request pulse and fields
//   d_resp_en, d_resp_data       data response pulse and data (0 for writes)
//   mem_req_en, mem_req_mode,
//   mem_req_addr, mem_req_wdata,
//   mem_req_wstrb                cache request (enable is a one-cycle pulse;
//                                fields hold between requests)
//   mem_resp_en, mem_resp_data   cache response
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   : ties alternate, granting the requester not granted last
//   undefined : fixed priority, data wins every tie
// ---------------------------------------------------------------------------
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_resp_en,
   output logic [31:0] i_resp_data,
   input  logic        d_req,
   input  logic        d_mode,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        d_resp_en,
   output logic [31:0] d_resp_data,
   output logic        mem_req_en,
   output logic        mem_req_mode,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_wstrb,
   input  logic        mem_resp_en,
   input  logic [31:0] mem_resp_data
);

   arb_state_t  r_state,        w_state_next;
   arb_owner_t  r_last_grant,   w_last_grant_next;
   logic        r_mem_req_en,   w_mem_req_en_next;
   memreq_t     r_mem_req,      w_mem_req_next;
   logic        r_i_resp_en,    w_i_resp_en_next;
   logic [31:0] r_i_resp_data,  w_i_resp_data_next;
   logic        r_d_resp_en,    w_d_resp_en_next;
   logic [31:0] r_d_resp_data,  w_d_resp_data_next;

   logic        w_grant_i, w_grant_d;
   logic        w_pend_i,  w_pend_d;
   logic        w_cand_i,  w_cand_d;
   logic        w_tie_pick_d;
   logic        w_pick_d;
   memreq_t     w_req_i,   w_req_d;
   memreq_t     w_live_i,  w_live_d;

   assign w_live_i = fetch_req(i_addr);
   assign w_live_d = '{mode: d_mode, addr: d_addr, wdata: d_wdata, wstrb: d_wstrb};

   memreq_latch u_latch_i (
      .clk       (clk),
      .rstn      (rstn),
      .i_pulse   (i_req),
      .i_fields  (w_live_i),
      .i_block   (r_state == WAIT_I),
      .i_clear   (w_grant_i),
      .o_pending (w_pend_i),
      .o_fields  (w_req_i)
   );

   memreq_latch u_latch_d (
      .clk       (clk),
      .rstn      (rstn),
      .i_pulse   (d_req),
      .i_fields  (w_live_d),
      .i_block   (r_state == WAIT_D),
      .i_clear   (w_grant_d),
      .o_pending (w_pend_d),
      .o_fields  (w_req_d)
   );

   // Candidates only matter in IDLE, where nothing is outstanding, so a live
   // pulse is always acceptable there.
   assign w_cand_i = w_pend_i | i_req;
   assign w_cand_d = w_pend_d | d_req;

`ifdef ARB_ROUND_ROBIN_EN
   assign w_tie_pick_d = (r_last_grant == OWNER_I);
`else
   assign w_tie_pick_d = 1'b1;
`endif

   assign w_pick_d = w_cand_d && (!w_cand_i || w_tie_pick_d);

   always_comb begin
      w_state_next       = r_state;
      w_last_grant_next  = r_last_grant;
      w_mem_req_en_next  = 1'b0;
      w_mem_req_next     = r_mem_req;
      w_i_resp_en_next   = 1'b0;
      w_i_resp_data_next = r_i_resp_data;
      w_d_resp_en_next   = 1'b0;
      w_d_resp_data_next = r_d_resp_data;
      w_grant_i          = 1'b0;
      w_grant_d          = 1'b0;

      case (r_state)
         IDLE: begin
            // Responses arriving here have no owner and are dropped.
            if (w_cand_i || w_cand_d) begin
               w_mem_req_en_next = 1'b1;
               if (w_pick_d) begin
                  w_grant_d         = 1'b1;
                  w_mem_req_next    = w_req_d;
                  w_state_next      = WAIT_D;
                  w_last_grant_next = OWNER_D;
               end else begin
                  w_grant_i         = 1'b1;
                  w_mem_req_next    = w_req_i;
                  w_state_next      = WAIT_I;
                  w_last_grant_next = OWNER_I;
               end
            end
         end
         WAIT_I: begin
            if (mem_resp_en) begin
               w_i_resp_en_next   = 1'b1;
               w_i_resp_data_next = mem_resp_data;
               w_state_next       = IDLE;
            end
         end
         WAIT_D: begin
            if (mem_resp_en) begin
               w_d_resp_en_next   = 1'b1;
               // The outstanding request's mode is still held on the port.
               w_d_resp_data_next = (r_mem_req.mode == MEMREQ_WRITE) ? 32'h0 : mem_resp_data;
               w_state_next       = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state       <= IDLE;
         r_last_grant  <= OWNER_D;
         r_mem_req_en  <= 1'b0;
         r_mem_req     <= '0;
         r_i_resp_en   <= 1'b0;
         r_i_resp_data <= 32'h0;
         r_d_resp_en   <= 1'b0;
         r_d_resp_data <= 32'h0;
      end else begin
         r_state       <= w_state_next;
         r_last_grant  <= w_last_grant_next;
         r_mem_req_en  <= w_mem_req_en_next;
         r_mem_req     <= w_mem_req_next;
         r_i_resp_en   <= w_i_resp_en_next;
         r_i_resp_data <= w_i_resp_data_next;
         r_d_resp_en   <= w_d_resp_en_next;
         r_d_resp_data <= w_d_resp_data_next;
      end
   end

   assign mem_req_en    = r_mem_req_en;
   assign mem_req_mode  = r_mem_req.mode;
   assign mem_req_addr  = r_mem_req.addr;
   assign mem_req_wdata = r_mem_req.wdata;
   assign mem_req_wstrb = r_mem_req.wstrb;
   assign i_resp_en     = r_i_resp_en;
   assign i_resp_data   = r_i_resp_data;
   assign d_resp_en     = r_d_resp_en;
   assign d_resp_data   = r_d_resp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Randomized stimulus for mem_arbiter with a transaction-level reference
// model. The driver updates the model just before each rising edge and pushes
// the cache requests and responses the DUT must present after that edge; a
// separate monitor on the falling edge pops and compares them, and checks
// that request fields and response data hold between pulses.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic        clk;
   logic        rstn;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_resp_en;
   logic [31:0] i_resp_data;
   logic        d_req;
   logic        d_mode;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_resp_en;
   logic [31:0] d_resp_data;
   logic        mem_req_en;
   logic        mem_req_mode;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_resp_en;
   logic [31:0] mem_resp_data;

   mem_arbiter dut (
      .clk           (clk),
      .rstn          (rstn),
      .i_req         (i_req),
      .i_addr        (i_addr),
      .i_resp_en     (i_resp_en),
      .i_resp_data   (i_resp_data),
      .d_req         (d_req),
      .d_mode        (d_mode),
      .d_addr        (d_addr),
      .d_wdata       (d_wdata),
      .d_wstrb       (d_wstrb),
      .d_resp_en     (d_resp_en),
      .d_resp_data   (d_resp_data),
      .mem_req_en    (mem_req_en),
      .mem_req_mode  (mem_req_mode),
      .mem_req_addr  (mem_req_addr),
      .mem_req_wdata (mem_req_wdata),
      .mem_req_wstrb (mem_req_wstrb),
      .mem_resp_en   (mem_resp_en),
      .mem_resp_data (mem_resp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          stamp;
      logic        mode;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_exp_t;

   typedef struct {
      int          stamp;
      logic [31:0] data;
   } resp_exp_t;

   req_exp_t  exp_req_q[$];
   resp_exp_t exp_i_q[$];
   resp_exp_t exp_d_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp_v);
   endtask

   // ---------------- reference model state ----------------
   // Owners: 0 none, 1 fetch, 2 data.
   bit          m_pend_i, m_pend_d;
   logic [31:0] m_i_addr;
   logic        m_d_mode;
   logic [31:0] m_d_addr, m_d_wdata;
   logic [3:0]  m_d_wstrb;
   int          m_busy = 0;
   logic        m_busy_write;
   int          m_last = 2;
   int          m_issue = 0;
   int          m_delay = 1;
   int          rst_stamp = -1;

   // Advance the model over the upcoming rising edge using the inputs just driven.
   task automatic model_step();
      int        n;
      int        ob;
      int        w;
      bit        ci, cd;
      req_exp_t  e;
      resp_exp_t r;
      n = cyc + 1;
      if (!rstn) begin
         m_pend_i  = 0;
         m_pend_d  = 0;
         m_busy    = 0;
         m_last    = 2;
         rst_stamp = n;
         return;
      end
      if (m_busy != 0) begin
         ob = m_busy;
         if (mem_resp_en) begin
            r.stamp = n;
            if (ob == 1) begin
               r.data = mem_resp_data;
               exp_i_q.push_back(r);
            end else begin
               r.data = m_busy_write ? 32'h0 : mem_resp_data;
               exp_d_q.push_back(r);
            end
            m_busy = 0;
         end
         if (i_req && !m_pend_i && ob != 1) begin
            m_pend_i = 1;
            m_i_addr = i_addr;
         end
         if (d_req && !m_pend_d && ob != 2) begin
            m_pend_d  = 1;
            m_d_mode  = d_mode;
            m_d_addr  = d_addr;
            m_d_wdata = d_wdata;
            m_d_wstrb = d_wstrb;
         end
      end else begin
         ci = m_pend_i || i_req;
         cd = m_pend_d || d_req;
         if (ci || cd) begin
            if (ci && cd) begin
`ifdef ARB_ROUND_ROBIN_EN
               w = (m_last == 2) ? 1 : 2;
`else
               w = 2;
`endif
            end else begin
               w = ci ? 1 : 2;
            end
            e.stamp = n;
            if (w == 1) begin
               e.mode  = MEMREQ_READ;
               e.addr  = m_pend_i ? m_i_addr : i_addr;
               e.wdata = 32'h0;
               e.wstrb = 4'h0;
               m_pend_i = 0;
               if (d_req && !m_pend_d) begin
                  m_pend_d  = 1;
                  m_d_mode  = d_mode;
                  m_d_addr  = d_addr;
                  m_d_wdata = d_wdata;
                  m_d_wstrb = d_wstrb;
               end
            end else begin
               e.mode  = m_pend_d ? m_d_mode  : d_mode;
               e.addr  = m_pend_d ? m_d_addr  : d_addr;
               e.wdata = m_pend_d ? m_d_wdata : d_wdata;
               e.wstrb = m_pend_d ? m_d_wstrb : d_wstrb;
               m_pend_d = 0;
               m_busy_write = e.mode;
               if (i_req && !m_pend_i) begin
                  m_pend_i = 1;
                  m_i_addr = i_addr;
               end
            end
            exp_req_q.push_back(e);
            m_busy  = w;
            m_last  = w;
            m_issue = n;
            m_delay = $urandom_range(1, 4);
         end
      end
   endtask

   // ---------------- monitor ----------------
   logic        mh_mode;
   logic [31:0] mh_addr, mh_wdata, mh_idata, mh_ddata;
   logic [3:0]  mh_wstrb;
   bit          mon_exp;
   req_exp_t    mon_e;
   resp_exp_t   mon_r;

   initial begin
      mh_mode = 1'b0; mh_addr = 32'h0; mh_wdata = 32'h0; mh_wstrb = 4'h0;
      mh_idata = 32'h0; mh_ddata = 32'h0;
   end

   always @(negedge clk) begin
      if (rst_stamp == cyc) begin
         mh_mode = 1'b0; mh_addr = 32'h0; mh_wdata = 32'h0; mh_wstrb = 4'h0;
         mh_idata = 32'h0; mh_ddata = 32'h0;
      end
      mon_exp = (exp_req_q.size() > 0) && (exp_req_q[0].stamp == cyc);
      check("mem_req_en", {31'b0, mem_req_en}, {31'b0, mon_exp});
      if (mon_exp) begin
         mon_e    = exp_req_q.pop_front();
         mh_mode  = mon_e.mode;
         mh_addr  = mon_e.addr;
         mh_wdata = mon_e.wdata;
         mh_wstrb = mon_e.wstrb;
         $display("cycle %0d: cache req mode=%0d addr=%h wdata=%h wstrb=%h",
                  cyc, mon_e.mode, mon_e.addr, mon_e.wdata, mon_e.wstrb);
      end
      check("mem_req_mode",  {31'b0, mem_req_mode}, {31'b0, mh_mode});
      check("mem_req_addr",  mem_req_addr,  mh_addr);
      check("mem_req_wdata", mem_req_wdata, mh_wdata);
      check("mem_req_wstrb", {28'b0, mem_req_wstrb}, {28'b0, mh_wstrb});

      mon_exp = (exp_i_q.size() > 0) && (exp_i_q[0].stamp == cyc);
      check("i_resp_en", {31'b0, i_resp_en}, {31'b0, mon_exp});
      if (mon_exp) begin
         mon_r    = exp_i_q.pop_front();
         mh_idata = mon_r.data;
         $display("cycle %0d: fetch resp data=%h", cyc, mon_r.data);
      end
      check("i_resp_data", i_resp_data, mh_idata);

      mon_exp = (exp_d_q.size() > 0) && (exp_d_q[0].stamp == cyc);
      check("d_resp_en", {31'b0, d_resp_en}, {31'b0, mon_exp});
      if (mon_exp) begin
         mon_r    = exp_d_q.pop_front();
         mh_ddata = mon_r.data;
         $display("cycle %0d: data resp data=%h", cyc, mon_r.data);
      end
      check("d_resp_data", d_resp_data, mh_ddata);
   end

   // ---------------- driver ----------------
   // Cache response: the model's outstanding request is answered after a
   // random delay; occasionally a stray response is sent while idle.
   task automatic drive_cycle(input int pi, input int pd, input bit d_hold,
                              input int prst, input bit quiet);
      i_req  = ($urandom_range(0, 99) < pi);
      d_req  = d_hold ? 1'b1 : ($urandom_range(0, 99) < pd);
      i_addr  = {$urandom_range(0, 65535), 2'b00};
      d_mode  = $urandom_range(0, 1);
      d_addr  = {$urandom_range(0, 65535), 2'b00};
      d_wdata = $urandom;
      d_wstrb = $urandom_range(0, 15);
      mem_resp_data = $urandom;
      if (m_busy != 0) mem_resp_en = (cyc + 1 >= m_issue + m_delay);
      else             mem_resp_en = !quiet && ($urandom_range(0, 19) == 0);
      if (!rstn) rstn = ($urandom_range(0, 1) == 0);
      else       rstn = !($urandom_range(0, 999) < prst);
      model_step();
   endtask

   int pi_tab[6] = '{10, 50, 20, 100, 40, 30};
   int pd_tab[6] = '{10, 50,  0, 100, 40, 30};
   bit dh_tab[6] = '{0,   0,  1,   0,  0,  0};
   int pr_tab[6] = '{3,   3,  3,   3, 20,  5};

   initial begin
      rstn = 1'b0;
      i_req = 1'b0; i_addr = 32'h0;
      d_req = 1'b0; d_mode = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
      mem_resp_en = 1'b0; mem_resp_data = 32'h0;
      model_step();
      @(negedge clk); #2;
      rstn = 1'b0;
      model_step();
      // Directed opener: data write, then a lone fetch.
      @(negedge clk); #2;
      rstn = 1'b1;
      d_req = 1'b1; d_mode = MEMREQ_WRITE; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
      model_step();
      for (int k = 0; k < 12; k++) begin
         @(negedge clk); #2;
         d_req = 1'b0;
         i_req = (k == 6);
         i_addr = 32'h40;
         mem_resp_data = 32'h00000013;
         mem_resp_en = (m_busy != 0) && (cyc + 1 >= m_issue + m_delay);
         model_step();
      end
      for (int ph = 0; ph < 6; ph++) begin
         for (int k = 0; k < 600; k++) begin
            @(negedge clk); #2;
            drive_cycle(pi_tab[ph], pd_tab[ph], dh_tab[ph], pr_tab[ph], 1'b0);
         end
      end
      for (int k = 0; k < 40; k++) begin
         @(negedge clk); #2;
         drive_cycle(0, 0, 1'b0, 0, 1'b1);
         rstn = 1'b1;
      end
      @(negedge clk); #2;
      check("req_q_drained",    exp_req_q.size(), 0);
      check("i_resp_q_drained", exp_i_q.size(),   0);
      check("d_resp_q_drained", exp_d_q.size(),   0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
